// File: rtl/energy_counter_mc.sv
// Multi-channel I/Q energy meter: per-channel I^2+Q^2, block or EMA averaging
// over a 2^k window, pseudo-log2 encoded result with a one-cycle strobe.
module energy_counter_mc #(
    parameter int N_CHANNELS     = 4,
    parameter int DATA_WIDTH     = 18,
    parameter int MAX_LOG_WINDOW = 5
) (
    input  logic                               ipClk,
    input  logic                               ipReset,
    input  logic [4:0]                         ipLogWindow,
    input  logic                               ipMode,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0]   ipI,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0]   ipQ,
    input  logic [N_CHANNELS-1:0]              ipValid,
    output logic [N_CHANNELS*8-1:0]            opOutput,
    output logic [N_CHANNELS-1:0]              opValid
);

    localparam int EW = 2 * DATA_WIDTH;          // energy / mean width
    localparam int AW = EW + MAX_LOG_WINDOW;     // accumulator width
    localparam int CW = MAX_LOG_WINDOW + 1;      // sample counter width
    localparam int MW = $clog2(EW);              // MSB index width

    logic [4:0]    clampedWindow;
    logic [4:0]    cfgWindowReg;
    logic          cfgModeReg;
    logic          configChange;
    logic [CW-1:0] windowLen;
    logic [CW-1:0] lastCount;

    assign clampedWindow = (ipLogWindow > 5'(MAX_LOG_WINDOW)) ? 5'(MAX_LOG_WINDOW) : ipLogWindow;
    assign configChange  = (clampedWindow != cfgWindowReg) || (ipMode != cfgModeReg);
    assign windowLen     = CW'(1) << cfgWindowReg;
    assign lastCount     = windowLen - CW'(1);

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            cfgWindowReg <= '0;
            cfgModeReg   <= 1'b0;
        end else begin
            cfgWindowReg <= clampedWindow;
            cfgModeReg   <= ipMode;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CHANNELS; gi++) begin : gen_channel
            logic signed [DATA_WIDTH-1:0] sampleI;
            logic signed [DATA_WIDTH-1:0] sampleQ;
            logic signed [EW-1:0]         extI;
            logic signed [EW-1:0]         extQ;
            logic signed [EW-1:0]         prodI;
            logic signed [EW-1:0]         prodQ;

            logic [EW-1:0] sqIReg;
            logic [EW-1:0] sqQReg;
            logic          s1ValidReg;
            logic [EW-1:0] energyReg;
            logic          s2ValidReg;
            logic [AW-1:0] accReg;
            logic [CW-1:0] countReg;
            logic [EW-1:0] meanReg;
            logic          s3ValidReg;
            logic [7:0]    outReg;
            logic          outValidReg;

            logic [AW-1:0] energyExt;
            logic [AW-1:0] blockSum;
            logic [AW-1:0] emaSum;
            logic [AW-1:0] newSum;
            logic [EW-1:0] meanNext;
            logic          windowDone;

            logic [MW-1:0] msbIdx;
            logic [1:0]    frac;
            logic [7:0]    encoded;

            assign sampleI = ipI[gi*DATA_WIDTH +: DATA_WIDTH];
            assign sampleQ = ipQ[gi*DATA_WIDTH +: DATA_WIDTH];
            assign extI    = {{DATA_WIDTH{sampleI[DATA_WIDTH-1]}}, sampleI};
            assign extQ    = {{DATA_WIDTH{sampleQ[DATA_WIDTH-1]}}, sampleQ};
            assign prodI   = extI * extI;
            assign prodQ   = extQ * extQ;

            // Subtract before adding so the EMA intermediate never exceeds the accumulator.
            assign energyExt  = {{MAX_LOG_WINDOW{1'b0}}, energyReg};
            assign blockSum   = accReg + energyExt;
            assign emaSum     = accReg - (accReg >> cfgWindowReg) + energyExt;
            assign newSum     = cfgModeReg ? emaSum : blockSum;
            assign meanNext   = EW'(newSum >> cfgWindowReg);
            assign windowDone = (countReg == lastCount);

            always_comb begin
                msbIdx = '0;
                for (int b = 1; b < EW; b++) begin
                    if (meanReg[b]) msbIdx = MW'(b);
                end
                frac = 2'b00;
                if (msbIdx >= MW'(2)) begin
                    frac = 2'(meanReg >> (msbIdx - MW'(2)));
                end else if (msbIdx == MW'(1)) begin
                    frac = {meanReg[0], 1'b0};
                end
            end

            assign encoded = 8'({msbIdx, frac});

            always_ff @(posedge ipClk or negedge ipReset) begin
                if (!ipReset) begin
                    sqIReg      <= '0;
                    sqQReg      <= '0;
                    s1ValidReg  <= 1'b0;
                    energyReg   <= '0;
                    s2ValidReg  <= 1'b0;
                    accReg      <= '0;
                    countReg    <= '0;
                    meanReg     <= '0;
                    s3ValidReg  <= 1'b0;
                    outReg      <= '0;
                    outValidReg <= 1'b0;
                end else begin
                    // A sample arriving with a config change is kept: it is the first under the new config.
                    s1ValidReg <= ipValid[gi];
                    if (ipValid[gi]) begin
                        sqIReg <= prodI;
                        sqQReg <= prodQ;
                    end

                    s2ValidReg <= s1ValidReg && !configChange;
                    if (s1ValidReg) begin
                        energyReg <= sqIReg + sqQReg;
                    end

                    outValidReg <= s3ValidReg && !configChange;
                    if (s3ValidReg && !configChange) begin
                        outReg <= encoded;
                    end

                    if (configChange) begin
                        accReg     <= '0;
                        countReg   <= '0;
                        s3ValidReg <= 1'b0;
                    end else if (s2ValidReg) begin
                        if (cfgModeReg) begin
                            accReg     <= emaSum;
                            meanReg    <= meanNext;
                            s3ValidReg <= 1'b1;
                        end else if (windowDone) begin
                            accReg     <= '0;
                            countReg   <= '0;
                            meanReg    <= meanNext;
                            s3ValidReg <= 1'b1;
                        end else begin
                            accReg     <= blockSum;
                            countReg   <= countReg + CW'(1);
                            s3ValidReg <= 1'b0;
                        end
                    end else begin
                        s3ValidReg <= 1'b0;
                    end
                end
            end

            assign opOutput[gi*8 +: 8] = outReg;
            assign opValid[gi]         = outValidReg;
        end
    endgenerate

endmodule
